// File: rtl/hs_arith_umin_scan_sched.sv
// Sequential least-key scheduler: snapshots NUM_REQ (valid, key) pairs on start,
// folds them one per cycle through a single 2-input unsigned-minimum stage and
// presents the winner on a valid/ready grant port.
// Optional build macro HS_ARITH_UMIN_SCAN_SCHED_FAIR_EN: rotates the scan start
// to (last granted index + 1) so tie-break priority becomes round-robin.
module hs_arith_umin_scan_sched #(
  parameter  int NUM_REQ    = 8,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_key,
  output logic                          busy,
  output logic                          grant_valid,
  input  logic                          grant_ready,
  output logic [IDX_WIDTH-1:0]          grant_index,
  output logic [NUM_REQ-1:0]            grant_onehot,
  output logic [DATA_WIDTH-1:0]         grant_key,
  output logic                          no_grant
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  logic [1:0]            state;
  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  cnt;
  logic                  min_valid;
  logic [DATA_WIDTH-1:0] min_key;
  logic [IDX_WIDTH-1:0]  min_idx;
  logic [IDX_WIDTH-1:0]  first_ptr;

  logic [NUM_REQ-1:0]    snap_valid;
  logic [DATA_WIDTH-1:0] snap_key [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_key_arr [NUM_REQ];

  logic                  cand_valid;
  logic [DATA_WIDTH-1:0] cand_key;
  logic                  take;
  logic                  nxt_valid;
  logic [DATA_WIDTH-1:0] nxt_key;
  logic [IDX_WIDTH-1:0]  nxt_idx;
  logic                  load;

  // Unpack the flat key bus into per-requester lanes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_key_arr[gi] = req_key[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign load = (state == S_IDLE) && start;

  // Snapshot the request table when a scan is accepted; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      snap_valid <= req_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        snap_key[i] <= req_key_arr[i];
      end
    end
  end

`ifdef HS_ARITH_UMIN_SCAN_SCHED_FAIR_EN
  logic [IDX_WIDTH-1:0] last_grant;

  // Remember the most recently accepted winner; only a completed handshake moves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_IDX;
    end else if ((state == S_HOLD) && grant_ready) begin
      last_grant <= grant_index;
    end
  end

  assign first_ptr = (last_grant == LAST_IDX) ? '0 : last_grant + IDX_WIDTH'(1);
`else
  assign first_ptr = '0;
`endif

  // Single compare stage: running minimum (din0) versus snapshot[ptr] (din1).
  // Strict less-than keeps the earlier-scanned entry on ties.
  always_comb begin
    cand_valid = snap_valid[ptr];
    cand_key   = snap_key[ptr];
    take       = cand_valid && (!min_valid || (cand_key < min_key));
    nxt_valid  = min_valid || cand_valid;
    nxt_key    = take ? cand_key : min_key;
    nxt_idx    = take ? ptr : min_idx;
  end

  // Main FSM: IDLE -> SCAN (NUM_REQ compares) -> HOLD until accepted, or back to IDLE with no_grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      min_valid   <= 1'b0;
      min_key     <= '0;
      min_idx     <= '0;
      grant_index <= '0;
      grant_key   <= '0;
      no_grant    <= 1'b0;
    end else begin
      no_grant <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr       <= first_ptr;
            cnt       <= '0;
            min_valid <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          min_valid <= nxt_valid;
          min_key   <= nxt_key;
          min_idx   <= nxt_idx;
          ptr       <= (ptr == LAST_IDX) ? '0 : ptr + IDX_WIDTH'(1);
          cnt       <= cnt + IDX_WIDTH'(1);
          if (cnt == LAST_IDX) begin
            if (nxt_valid) begin
              grant_index <= nxt_idx;
              grant_key   <= nxt_key;
              state       <= S_HOLD;
            end else begin
              no_grant <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (grant_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign grant_valid = (state == S_HOLD);

  // One-hot view of the winner, forced to zero whenever no grant is presented.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_onehot[gi] = grant_valid && (grant_index == IDX_WIDTH'(gi));
  end

endmodule
